// File: rtl/dmem_rmw_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory controller: RV funct3 access
// sizes, controller states and small decode helpers.
package dmem_rmw_ctrl_pkg;

  typedef enum logic [2:0] {
    MASK_B  = 3'd0,
    MASK_H  = 3'd1,
    MASK_W  = 3'd2,
    MASK_BU = 3'd4,
    MASK_HU = 3'd5
  } mask_e;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_e;

  function automatic logic is_byte(input mask_e m);
    return (m == MASK_B) || (m == MASK_BU);
  endfunction

  function automatic logic is_half(input mask_e m);
    return (m == MASK_H) || (m == MASK_HU);
  endfunction

  // Unlisted funct3 codes fall through to word behaviour.
  function automatic logic is_word(input mask_e m);
    return !(is_byte(m) || is_half(m));
  endfunction

  function automatic logic misaligned(input mask_e m, input logic [1:0] off);
    if (is_byte(m)) return 1'b0;
    if (is_half(m)) return off[0];
    return off != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_rmw_ctrl_if.sv
// Pipeline request/response bus plus the single-port SRAM port of the
// data-memory controller.
interface dmem_rmw_ctrl_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              memRead;
  logic              memWrite;
  logic [2:0]        maskMode;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rdata_valid;
  logic              rmw_pending;
  logic              busy;
  logic              misalign;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output memRead, memWrite, maskMode, addr, wdata,
    input  rdata, rdata_valid, rmw_pending, busy, misalign
  );

  modport slave (
    input  memRead, memWrite, maskMode, addr, wdata, mem_rdata,
    output rdata, rdata_valid, rmw_pending, busy, misalign,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport sram (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_rmw_ctrl_lane_merge.sv
// Byte/half lane handling on a 32-bit SRAM word: store-side merge of new data
// into the old word, load-side lane extract with sign/zero extension.
module dmem_lane_merge
  import dmem_rmw_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [15:0] st_data,
  input  logic [1:0]  st_off,
  input  mask_e       st_mask,
  input  logic [1:0]  ld_off,
  input  mask_e       ld_mask,
  output logic [31:0] merged,
  output logic [31:0] loaded
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    merged = word;
    if (is_half(st_mask)) begin
      if (st_off[1]) merged[31:16] = st_data;
      else           merged[15:0]  = st_data;
    end else if (is_byte(st_mask)) begin
      merged[{st_off, 3'b000} +: 8] = st_data[7:0];
    end
  end

  always_comb begin
    ld_byte = word[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? word[31:16] : word[15:0];
    unique case (ld_mask)
      MASK_B:  loaded = {{24{ld_byte[7]}}, ld_byte};
      MASK_BU: loaded = {24'h0, ld_byte};
      MASK_H:  loaded = {{16{ld_half[15]}}, ld_half};
      MASK_HU: loaded = {16'h0, ld_half};
      default: loaded = word;
    endcase
  end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// MEM-stage data-memory controller: single-cycle word stores, two-cycle
// read-modify-write for sb/sh, one-cycle-latency extended loads.
module dmem_rmw_ctrl
  import dmem_rmw_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_rmw_ctrl_if.slave bus
);

  state_e            state_q, state_d;

  logic [ADDR_W-1:0] rmw_addr_q;
  logic [1:0]        rmw_off_q;
  mask_e             rmw_mask_q;
  logic [15:0]       rmw_data_q;

  logic              ld_valid_q;
  logic [1:0]        ld_off_q;
  mask_e             ld_mask_q;

  mask_e             req_mask;
  logic              req;
  logic              ld_issue;
  logic              rmw_issue;

  logic              en;
  logic              we;
  logic [ADDR_W-1:0] maddr;
  logic [31:0]       mwdata;
  logic              bsy;
  logic              mis;
  logic              pend;

  logic [31:0]       merged;
  logic [31:0]       loaded;
  logic              unused_addr_hi;

  assign req_mask       = mask_e'(bus.maskMode);
  assign req            = bus.memRead | bus.memWrite;
  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

  dmem_lane_merge u_lane (
    .word    (bus.mem_rdata),
    .st_data (rmw_data_q),
    .st_off  (rmw_off_q),
    .st_mask (rmw_mask_q),
    .ld_off  (ld_off_q),
    .ld_mask (ld_mask_q),
    .merged  (merged),
    .loaded  (loaded)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rmw_addr_q <= '0;
      rmw_off_q  <= '0;
      rmw_mask_q <= MASK_B;
      rmw_data_q <= '0;
      ld_valid_q <= 1'b0;
      ld_off_q   <= '0;
      ld_mask_q  <= MASK_B;
    end else begin
      state_q    <= state_d;
      ld_valid_q <= ld_issue;
      if (ld_issue) begin
        ld_off_q  <= bus.addr[1:0];
        ld_mask_q <= req_mask;
      end
      if (rmw_issue) begin
        rmw_addr_q <= bus.addr[ADDR_W+1:2];
        rmw_off_q  <= bus.addr[1:0];
        rmw_mask_q <= req_mask;
        rmw_data_q <= bus.wdata[15:0];
      end
    end
  end

  // A request arriving during the write phase is only flagged busy; the
  // requester holds it and it is issued from IDLE on the following cycle.
  always_comb begin
    state_d   = state_q;
    ld_issue  = 1'b0;
    rmw_issue = 1'b0;
    en        = 1'b0;
    we        = 1'b0;
    maddr     = bus.addr[ADDR_W+1:2];
    mwdata    = '0;
    bsy       = 1'b0;
    mis       = 1'b0;
    pend      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (misaligned(req_mask, bus.addr[1:0])) begin
            mis = 1'b1;
          end else if (bus.memWrite) begin
            en = 1'b1;
            if (is_word(req_mask)) begin
              we     = 1'b1;
              mwdata = bus.wdata;
            end else begin
              rmw_issue = 1'b1;
              state_d   = RMW_WR;
            end
          end else begin
            en       = 1'b1;
            ld_issue = 1'b1;
          end
        end
      end
      RMW_WR: begin
        pend    = 1'b1;
        en      = 1'b1;
        we      = 1'b1;
        maddr   = rmw_addr_q;
        mwdata  = merged;
        bsy     = req;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is held so an in-flight RMW write
  // never reaches the SRAM.
  assign bus.mem_en      = rst_n & en;
  assign bus.mem_we      = rst_n & we;
  assign bus.mem_addr    = rst_n ? maddr  : '0;
  assign bus.mem_wdata   = rst_n ? mwdata : '0;
  assign bus.busy        = rst_n & bsy;
  assign bus.misalign    = rst_n & mis;
  assign bus.rmw_pending = rst_n & pend;
  assign bus.rdata_valid = rst_n & ld_valid_q;
  assign bus.rdata       = (rst_n && ld_valid_q) ? loaded : '0;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Directed bench for dmem_rmw_ctrl against a behavioural single-port sync SRAM.
module tb_dmem_rmw_ctrl;
  import dmem_rmw_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dmem_rmw_ctrl_if #(.ADDR_W(10)) bus ();

  dmem_rmw_ctrl #(.ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] sram [1024];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= sram[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic req(input logic rd, input logic wr, input logic [2:0] mm,
                     input logic [31:0] a, input logic [31:0] wd);
    bus.memRead  = rd;
    bus.memWrite = wr;
    bus.maskMode = mm;
    bus.addr     = a;
    bus.wdata    = wd;
  endtask

  task automatic nop();
    req(1'b0, 1'b0, MASK_W, 32'h0, 32'h0);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.mem_rdata = '0;
    rst_n = 1'b0;
    req(1'b0, 1'b1, MASK_W, 32'h10, 32'h12345678);
    repeat (2) adv();
    @(negedge clk);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_pend", bus.rmw_pending, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.rdata_valid, 0);
    check("rst_misalign", bus.misalign, 0);
    adv();
    rst_n = 1'b1;

    // sw then lw, one-cycle load latency
    req(1'b0, 1'b1, MASK_W, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    check("sw_en", bus.mem_en, 1);
    check("sw_we", bus.mem_we, 1);
    check("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("sw_addr", bus.mem_addr, 32'h4);
    check("sw_busy", bus.busy, 0);
    adv();
    req(1'b1, 1'b0, MASK_W, 32'h10, 32'h0);
    @(negedge clk);
    check("lw_en", bus.mem_en, 1);
    check("lw_we", bus.mem_we, 0);
    check("lw_valid_early", bus.rdata_valid, 0);
    adv();
    nop();
    @(negedge clk);
    check("lw_valid", bus.rdata_valid, 1);
    check("lw_rdata", bus.rdata, 32'hDEADBEEF);
    adv();
    @(negedge clk);
    check("lw_valid_drop", bus.rdata_valid, 0);
    adv();

    // sb into 0x11223344
    req(1'b0, 1'b1, MASK_W, 32'h20, 32'h11223344);
    adv();
    req(1'b0, 1'b1, MASK_B, 32'h21, 32'h000000AA);
    @(negedge clk);
    check("sb_rd_en", bus.mem_en, 1);
    check("sb_rd_we", bus.mem_we, 0);
    check("sb_rd_pend", bus.rmw_pending, 0);
    adv();
    nop();
    @(negedge clk);
    check("sb_wr_pend", bus.rmw_pending, 1);
    check("sb_wr_we", bus.mem_we, 1);
    check("sb_wr_addr", bus.mem_addr, 32'h8);
    check("sb_wr_wdata", bus.mem_wdata, 32'h1122AA44);
    check("sb_wr_busy", bus.busy, 0);
    adv();
    @(negedge clk);
    check("sb_done_pend", bus.rmw_pending, 0);
    adv();

    // byte loads, back to back
    req(1'b0, 1'b1, MASK_W, 32'h20, 32'h80000000);
    adv();
    req(1'b1, 1'b0, MASK_B, 32'h23, 32'h0);
    adv();
    req(1'b1, 1'b0, MASK_BU, 32'h23, 32'h0);
    @(negedge clk);
    check("lb_rdata", bus.rdata, 32'hFFFFFF80);
    adv();
    nop();
    @(negedge clk);
    check("lbu_rdata", bus.rdata, 32'h00000080);
    adv();

    // half loads
    req(1'b0, 1'b1, MASK_W, 32'h20, 32'h80011234);
    adv();
    req(1'b1, 1'b0, MASK_H, 32'h22, 32'h0);
    adv();
    req(1'b1, 1'b0, MASK_HU, 32'h22, 32'h0);
    @(negedge clk);
    check("lh_hi_rdata", bus.rdata, 32'hFFFF8001);
    adv();
    req(1'b1, 1'b0, MASK_H, 32'h20, 32'h0);
    @(negedge clk);
    check("lhu_hi_rdata", bus.rdata, 32'h00008001);
    adv();
    nop();
    @(negedge clk);
    check("lh_lo_rdata", bus.rdata, 32'h00001234);
    adv();

    // sh followed by colliding lw
    req(1'b0, 1'b1, MASK_W, 32'h30, 32'hCAFEF00D);
    adv();
    req(1'b0, 1'b1, MASK_H, 32'h30, 32'hABCD5678);
    @(negedge clk);
    check("sh_rd_busy", bus.busy, 0);
    adv();
    req(1'b1, 1'b0, MASK_W, 32'h30, 32'h0);
    @(negedge clk);
    check("coll_busy", bus.busy, 1);
    check("coll_pend", bus.rmw_pending, 1);
    check("coll_wdata", bus.mem_wdata, 32'hCAFE5678);
    adv();
    @(negedge clk);
    check("coll_busy_drop", bus.busy, 0);
    check("coll_lw_en", bus.mem_en, 1);
    check("coll_lw_we", bus.mem_we, 0);
    check("coll_lw_addr", bus.mem_addr, 32'hC);
    adv();
    nop();
    @(negedge clk);
    check("coll_lw_valid", bus.rdata_valid, 1);
    check("coll_lw_rdata", bus.rdata, 32'hCAFE5678);
    adv();

    // store and load together: store wins
    req(1'b1, 1'b1, MASK_W, 32'h40, 32'h55AA55AA);
    @(negedge clk);
    check("rdwr_we", bus.mem_we, 1);
    adv();
    nop();
    @(negedge clk);
    check("rdwr_no_valid", bus.rdata_valid, 0);
    adv();

    // misaligned accesses
    req(1'b1, 1'b0, MASK_H, 32'h31, 32'h0);
    @(negedge clk);
    check("mis_lh_pulse", bus.misalign, 1);
    check("mis_lh_en", bus.mem_en, 0);
    adv();
    nop();
    @(negedge clk);
    check("mis_lh_drop", bus.misalign, 0);
    check("mis_lh_valid", bus.rdata_valid, 0);
    adv();
    req(1'b0, 1'b1, MASK_W, 32'h42, 32'h0BADF00D);
    @(negedge clk);
    check("mis_sw_pulse", bus.misalign, 1);
    check("mis_sw_en", bus.mem_en, 0);
    adv();
    req(1'b1, 1'b0, MASK_W, 32'h40, 32'h0);
    adv();
    nop();
    @(negedge clk);
    check("mis_sw_kept", bus.rdata, 32'h55AA55AA);
    adv();

    // reset during RMW_WR aborts the write
    req(1'b0, 1'b1, MASK_W, 32'h50, 32'h01020304);
    adv();
    req(1'b0, 1'b1, MASK_B, 32'h50, 32'h000000FF);
    adv();
    nop();
    rst_n = 1'b0;
    @(negedge clk);
    check("rstrmw_we", bus.mem_we, 0);
    check("rstrmw_en", bus.mem_en, 0);
    check("rstrmw_pend", bus.rmw_pending, 0);
    adv();
    rst_n = 1'b1;
    req(1'b1, 1'b0, MASK_W, 32'h50, 32'h0);
    @(negedge clk);
    check("rstrmw_idle_pend", bus.rmw_pending, 0);
    check("rstrmw_lw_we", bus.mem_we, 0);
    check("rstrmw_lw_en", bus.mem_en, 1);
    adv();
    nop();
    @(negedge clk);
    check("rstrmw_word", bus.rdata, 32'h01020304);
    adv();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
